// File: rtl/core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core                                                            |
// | Purpose  : Single-issue 16-bit CPU core, one instruction committed per     |
// |            cycle. Fetch and load data arrive combinationally from a shared |
// |            memory. An external arbiter can freeze the core for a few       |
// |            cycles after a commit through stall_num.                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          rising-edge clock                                           |
// |   rst_n        synchronous active-low reset                                |
// |   halt         sticky, set by an undefined opcode / sub-field              |
// |   pc_passed    start byte address loaded into pc on reset ([15:0] used)    |
// |   stall_num    idle cycles inserted after the current commit               |
// |   pc           byte address of the current instruction                     |
// |   rdata0       instruction word at pc                                      |
// |   raddr1       {load active, load word address}                            |
// |   rdata1       load data ([15:0] used)                                     |
// |   wen/waddr/wdata  store strobe, word address and data                     |
// |   pauseResume  {valid, run, target} request to the arbiter                 |
// |   debug        trace enable, only meaningful with CORE_TRACE_EN            |
// +----------------------------------------------------------------------------+
// | Build option: define CORE_TRACE_EN to $display each commit when debug = 1. |
// +----------------------------------------------------------------------------+
module core #(
  parameter int RESET_PC_W = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  halt,
  input  logic [RESET_PC_W-1:0] pc_passed,
  input  logic [2:0]            stall_num,
  output logic [15:0]           pc,
  input  logic [15:0]           rdata0,
  output logic [16:1]           raddr1,
  input  logic [16:0]           rdata1,
  output logic                  wen,
  output logic [15:1]           waddr,
  output logic [15:0]           wdata,
  output logic [2:0]            pauseResume,
  input  logic                  debug
);

  localparam logic [3:0] c_OP_SUB  = 4'b0000;
  localparam logic [3:0] c_OP_PR   = 4'b0001;
  localparam logic [3:0] c_OP_MOVL = 4'b1000;
  localparam logic [3:0] c_OP_MOVH = 4'b1001;
  localparam logic [3:0] c_OP_JMP  = 4'b1110;
  localparam logic [3:0] c_OP_MEM  = 4'b1111;

  logic [15:0] r_pc;
  logic        r_halt;
  logic [2:0]  r_idle;
  logic [15:0] r_regs [16];

  // Instruction fields
  logic [3:0]  w_op, w_ra, w_rb, w_rt;
  logic [7:0]  w_imm8;
  assign w_op   = rdata0[15:12];
  assign w_ra   = rdata0[11:8];
  assign w_rb   = rdata0[7:4];
  assign w_rt   = rdata0[3:0];
  assign w_imm8 = rdata0[11:4];

  // Register reads; r0 is hard-wired to zero regardless of storage contents
  logic [15:0] w_a, w_b, w_t;
  assign w_a = (w_ra == 4'd0) ? 16'd0 : r_regs[w_ra];
  assign w_b = (w_rb == 4'd0) ? 16'd0 : r_regs[w_rb];
  assign w_t = (w_rt == 4'd0) ? 16'd0 : r_regs[w_rt];

  // Decode
  logic        w_we, w_undef, w_wen, w_ld, w_taken;
  logic [15:0] w_wval, w_npc;
  logic [2:0]  w_pr;

  always_comb begin
    w_we    = 1'b0;
    w_wval  = 16'd0;
    w_npc   = r_pc + 16'd2;
    w_undef = 1'b0;
    w_wen   = 1'b0;
    w_ld    = 1'b0;
    w_pr    = 3'b000;
    w_taken = 1'b0;
    case (w_op)
      c_OP_SUB: begin
        w_we   = 1'b1;
        w_wval = w_a - w_b;
      end
      c_OP_MOVL: begin
        w_we   = 1'b1;
        w_wval = {{8{w_imm8[7]}}, w_imm8};
      end
      c_OP_MOVH: begin
        w_we   = 1'b1;
        w_wval = {w_imm8, w_t[7:0]};
      end
      c_OP_JMP: begin
        case (w_rb)
          4'd0:    w_taken = (w_a == 16'd0);
          4'd1:    w_taken = (w_a != 16'd0);
          4'd2:    w_taken = w_a[15];
          4'd3:    w_taken = ~w_a[15];
          default: w_undef = 1'b1;
        endcase
        if (w_taken) begin
          w_npc = {w_t[15:1], 1'b0};
        end
      end
      c_OP_MEM: begin
        case (w_rb)
          4'd0: begin
            w_ld   = 1'b1;
            w_we   = 1'b1;
            w_wval = rdata1[15:0];
          end
          4'd1:    w_wen = 1'b1;
          default: w_undef = 1'b1;
        endcase
      end
      c_OP_PR: w_pr = {1'b1, w_rt[1], w_rt[0]};
      default: w_undef = 1'b1;
    endcase
  end

  // The core presents an instruction only when out of reset, not halted and
  // not serving an idle window; stall_num deliberately plays no part here.
  logic w_active;
  logic w_commit;
  assign w_active = rst_n & ~r_halt & (r_idle == 3'd0);
  assign w_commit = w_active & ~w_undef;

  assign pc          = r_pc;
  assign halt        = r_halt;
  assign wen         = w_active & w_wen;
  assign waddr       = (w_active & w_wen) ? w_a[15:1] : 15'd0;
  assign wdata       = (w_active & w_wen) ? w_t : 16'd0;
  assign raddr1      = (w_active & w_ld) ? {1'b1, w_a[15:1]} : 16'd0;
  assign pauseResume = w_active ? w_pr : 3'b000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc   <= pc_passed[15:0];
      r_halt <= 1'b0;
      r_idle <= 3'd0;
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= 16'd0;
      end
    end else if (r_halt) begin
      // frozen until reset
    end else if (r_idle != 3'd0) begin
      r_idle <= r_idle - 3'd1;
    end else if (w_undef) begin
      r_halt <= 1'b1;
    end else begin
      if (w_we && (w_rt != 4'd0)) begin
        r_regs[w_rt] <= w_wval;
      end
      r_pc   <= w_npc;
      r_idle <= stall_num;
    end
  end

`ifdef CORE_TRACE_EN
  always_ff @(posedge clk) begin
    if (w_commit && debug) begin
      if (w_we && (w_rt != 4'd0))
        $display("core trace: pc=%04h insn=%04h r%0d=%04h", r_pc, rdata0, w_rt, w_wval);
      else
        $display("core trace: pc=%04h insn=%04h", r_pc, rdata0);
    end
  end
`else
  logic w_unused_debug;
  assign w_unused_debug = debug ^ w_commit;
`endif

  // Upper bits of the wide inputs carry no meaning for this core
  logic w_unused_bits;
  assign w_unused_bits = ^{rdata1[16], pc_passed[RESET_PC_W-1:16]};

endmodule
`default_nettype wire

// File: tb/tb_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_core                                                         |
// | Purpose  : Directed program run on core with a memory-side scoreboard for  |
// |            store, load and pause/resume events plus direct pc/halt checks. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic [16:0] pc_passed;
  logic [2:0]  stall_num;
  logic [15:0] pc;
  logic [15:0] rdata0;
  logic [16:1] raddr1;
  logic [16:0] rdata1;
  logic        wen;
  logic [15:1] waddr;
  logic [15:0] wdata;
  logic [2:0]  pauseResume;
  logic        debug;

  logic [15:0] imem [0:32767];

  typedef struct packed {
    logic        wen;
    logic [14:0] waddr;
    logic [15:0] wdata;
    logic [15:0] raddr1;
    logic [2:0]  pr;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  core #(.RESET_PC_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .pc_passed(pc_passed),
    .stall_num(stall_num), .pc(pc), .rdata0(rdata0), .raddr1(raddr1),
    .rdata1(rdata1), .wen(wen), .waddr(waddr), .wdata(wdata),
    .pauseResume(pauseResume), .debug(debug)
  );

  always #5 clk = ~clk;
  assign rdata0 = imem[pc[15:1]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [15:0] target, input string name);
    int n = 0;
    while (pc !== target && n < 200) begin
      step();
      n++;
    end
    check(name, 64'(pc), 64'(target));
  endtask

  function automatic void exp_st(input logic [14:0] a, input logic [15:0] d);
    exp_q.push_back('{wen: 1'b1, waddr: a, wdata: d, raddr1: 16'h0, pr: 3'b000});
  endfunction

  function automatic void put(input logic [15:0] addr, input logic [15:0] insn);
    imem[addr[15:1]] = insn;
  endfunction

  // Monitor: any memory-side or arbiter-side event is matched against the queue
  initial begin
    ev_t act;
    ev_t exp;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (wen || raddr1[16] || pauseResume[2])) begin
        act = '{wen: wen, waddr: waddr, wdata: wdata, raddr1: raddr1, pr: pauseResume};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          check("mem_event", 64'(act), 64'(exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) imem[i] = 16'h0000;
    put(16'h0200, 16'h8FF1); // movl r1,0xFF
    put(16'h0202, 16'hF011); // st r1 -> [r0]
    put(16'h0204, 16'h8051); // movl r1,5
    put(16'h0206, 16'h8032); // movl r2,3
    put(16'h0208, 16'h0123); // sub r3,r1,r2
    put(16'h020A, 16'h8104); // movl r4,0x10
    put(16'h020C, 16'hF413); // st r3 -> [r4]
    put(16'h020E, 16'h0213); // sub r3,r2,r1
    put(16'h0210, 16'hF413); // st r3 -> [r4]
    put(16'h0212, 16'h0120); // sub r0,r1,r2 (discarded)
    put(16'h0214, 16'hF410); // st r0 -> [r4]
    put(16'h0216, 16'h8345); // movl r5,0x34
    put(16'h0218, 16'h9125); // movh r5,0x12
    put(16'h021A, 16'hF415); // st r5 -> [r4]  (stalled)
    put(16'h021C, 16'hF406); // ld r6 <- [r4]
    put(16'h021E, 16'hF016); // st r6 -> [r0]
    put(16'h0220, 16'h8417); // movl r7,0x41
    put(16'h0222, 16'hE017); // jnz r0 -> r7
    put(16'h0224, 16'hE007); // jz r0 -> r7
    put(16'h0040, 16'h1002); // pause/resume rt=0b10
    put(16'h0042, 16'h7000); // undefined

    exp_st(15'h0000, 16'hFFFF);
    exp_st(15'h0008, 16'h0002);
    exp_st(15'h0008, 16'hFFFE);
    exp_st(15'h0008, 16'h0000);
    exp_st(15'h0008, 16'h1234);
    exp_q.push_back('{wen: 1'b0, waddr: 15'h0, wdata: 16'h0, raddr1: 16'h8008, pr: 3'b000});
    exp_st(15'h0000, 16'hABCD);
    exp_q.push_back('{wen: 1'b0, waddr: 15'h0, wdata: 16'h0, raddr1: 16'h0, pr: 3'b110});

    rst_n     = 1'b0;
    pc_passed = 17'h00200;
    stall_num = 3'd0;
    rdata1    = 17'h1ABCD;
    debug     = 1'b0;
    step();
    step();
    check("reset_pc", 64'(pc), 64'h200);
    check("reset_halt", 64'(halt), 64'h0);
    check("reset_wen", 64'(wen), 64'h0);
    rst_n = 1'b1;
    step();
    check("pc_after_movl", 64'(pc), 64'h202);

    wait_pc(16'h021A, "reach_stall_st");
    stall_num = 3'd6;
    step();
    stall_num = 3'd0;
    for (int i = 0; i < 6; i++) begin
      check("stall_pc_hold", 64'(pc), 64'h21C);
      check("stall_outputs_zero", 64'({wen, raddr1}), 64'h0);
      step();
    end
    check("post_stall_ld_addr", 64'(raddr1), 64'h8008);

    wait_pc(16'h0222, "reach_jnz");
    step();
    check("jnz_not_taken", 64'(pc), 64'h224);
    step();
    check("jz_taken", 64'(pc), 64'h040);
    step();
    check("pc_after_pause", 64'(pc), 64'h042);
    step();
    check("halt_set", 64'(halt), 64'h1);
    check("halt_pc", 64'(pc), 64'h042);
    for (int i = 0; i < 4; i++) step();
    check("halt_sticky", 64'(halt), 64'h1);
    check("halt_pc_frozen", 64'(pc), 64'h042);

    rst_n     = 1'b0;
    pc_passed = 17'h00100;
    step();
    check("rereset_halt", 64'(halt), 64'h0);
    check("rereset_pc", 64'(pc), 64'h100);
    rst_n = 1'b1;
    step();
    step();
    check("events_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
